// File: rtl/encoder_8_3_rr_pkg.sv
// Shared constants, FSM state encoding and grant record for the 8-to-3 request encoder.
package encoder_8_3_rr_pkg;

    localparam int ENC_N = 8;
    localparam int ENC_W = 3;

    typedef enum logic {
        ENC_IDLE = 1'b0,
        ENC_HOLD = 1'b1
    } enc_state_e;

    typedef struct packed {
        logic [ENC_W-1:0] idx;
        logic [ENC_N-1:0] onehot;
    } enc_grant_t;

    function automatic logic [ENC_N-1:0] enc_onehot(input logic [ENC_W-1:0] idx);
        logic [ENC_N-1:0] one;
        one = {{(ENC_N-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/encoder_8_3_rr_if.sv
// Request/grant bundle between a request source (master) and the encoder (slave).
interface encoder_8_3_rr_if;
    import encoder_8_3_rr_pkg::*;

    logic [ENC_N-1:0] req;
    logic             out_valid;
    logic             out_ready;
    logic [ENC_W-1:0] out_idx;
    logic [ENC_N-1:0] out_onehot;
    logic             busy;

    modport master (
        output req,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  out_onehot,
        input  busy
    );

    modport slave (
        input  req,
        input  out_ready,
        output out_valid,
        output out_idx,
        output out_onehot,
        output busy
    );

endinterface

// File: rtl/encoder_8_3_rr_pick.sv
// Combinational rotating-priority pick: first set bit of req at or after ptr, modulo 8.
module rr_pick_8
    import encoder_8_3_rr_pkg::*;
(
    input  logic [ENC_N-1:0] req,
    input  logic [ENC_W-1:0] ptr,
    output logic [ENC_W-1:0] idx,
    output logic             any
);

    logic [2*ENC_N-1:0] dbl;
    logic [ENC_N-1:0]   rot;
    logic [ENC_W-1:0]   off;

    // Rotate so that bit ptr lands at position 0, then take the lowest set bit.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[ENC_N-1:0];
        off = '0;
        for (int i = ENC_N - 1; i >= 0; i--) begin
            if (rot[i]) off = ENC_W'(i);
        end
        idx = ptr + off;
        any = |req;
    end

endmodule

// File: rtl/encoder_8_3_rr.sv
// Registered 8-to-3 request encoder with valid/ready hold.
// ENCODER_ROUND_ROBIN_EN selects rotating priority; otherwise fixed lowest-index priority.
module encoder_8_3_rr
    import encoder_8_3_rr_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    encoder_8_3_rr_if.slave   bus
);

    enc_state_e       state;
    enc_grant_t       grant;
    logic             valid;
    logic [ENC_W-1:0] pick_ptr;
    logic [ENC_W-1:0] pick_idx;
    logic             pick_any;
    logic             handshake;

    assign handshake = (state == ENC_HOLD) && bus.out_ready;

`ifdef ENCODER_ROUND_ROBIN_EN
    logic [ENC_W-1:0] ptr;

    // In HOLD the next winner is chosen with the pointer as it will be after this handshake.
    assign pick_ptr = (state == ENC_HOLD) ? grant.idx + ENC_W'(1) : ptr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (handshake) begin
            ptr <= grant.idx + ENC_W'(1);
        end
    end
`else
    assign pick_ptr = '0;
`endif

    rr_pick_8 u_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= ENC_IDLE;
            valid        <= 1'b0;
            grant.idx    <= '0;
            grant.onehot <= '0;
        end else begin
            case (state)
                ENC_IDLE: begin
                    if (pick_any) begin
                        state        <= ENC_HOLD;
                        valid        <= 1'b1;
                        grant.idx    <= pick_idx;
                        grant.onehot <= enc_onehot(pick_idx);
                    end
                end
                ENC_HOLD: begin
                    if (handshake) begin
                        if (pick_any) begin
                            grant.idx    <= pick_idx;
                            grant.onehot <= enc_onehot(pick_idx);
                        end else begin
                            state        <= ENC_IDLE;
                            valid        <= 1'b0;
                            grant.onehot <= '0;
                        end
                    end
                end
                default: begin
                    state        <= ENC_IDLE;
                    valid        <= 1'b0;
                    grant.onehot <= '0;
                end
            endcase
        end
    end

    assign bus.out_valid  = valid;
    assign bus.busy       = valid;
    assign bus.out_idx    = grant.idx;
    assign bus.out_onehot = grant.onehot;

endmodule

// File: tb/tb_encoder_8_3_rr.sv
// Directed-vector bench: stimulus pushes expected grants, a negedge monitor pops them on handshake.
module tb_encoder_8_3_rr;
    import encoder_8_3_rr_pkg::*;

`ifdef ENCODER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    encoder_8_3_rr_if bus ();

    encoder_8_3_rr dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Inputs apply to the next rising edge; returns 1 time unit after it.
    task automatic step(input logic [7:0] r, input logic rdy);
        bus.req       = r;
        bus.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted grant must match the oldest expected one.
    always @(negedge clk) begin
        logic [2:0] e;
        if (resetn && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual_idx=%0d expected=none", bus.out_idx);
            end else begin
                e = exp_q.pop_front();
                check("sb_idx", 32'(bus.out_idx), 32'(e));
                check("sb_onehot", 32'(bus.out_onehot), 32'(8'd1 << e));
                check("sb_busy", 32'(bus.busy), 32'd1);
            end
        end
    end

    initial begin
        bus.req       = 8'h00;
        bus.out_ready = 1'b0;

        // Reset with all requests and ready high
        resetn = 1'b0;
        repeat (3) begin
            step(8'hFF, 1'b1);
            check("rst_valid", 32'(bus.out_valid), 32'd0);
            check("rst_idx", 32'(bus.out_idx), 32'd0);
            check("rst_onehot", 32'(bus.out_onehot), 32'd0);
        end
        resetn = 1'b1;

        // Single request, one-cycle latency, then accept and go idle
        exp_q.push_back(3'd5);
        step(8'h20, 1'b0);
        check("single_valid", 32'(bus.out_valid), 32'd1);
        step(8'h00, 1'b1);
        check("single_idle_valid", 32'(bus.out_valid), 32'd0);
        check("single_idle_onehot", 32'(bus.out_onehot), 32'd0);
        check("single_idle_busy", 32'(bus.busy), 32'd0);

        // Hold stability while req changes underneath
        exp_q.push_back(3'd3);
        step(8'h08, 1'b0);
        repeat (5) begin
            step(8'h81, 1'b0);
            check("hold_idx", 32'(bus.out_idx), 32'd3);
            check("hold_onehot", 32'(bus.out_onehot), 32'h08);
        end
        step(8'h00, 1'b1);
        check("hold_release", 32'(bus.out_valid), 32'd0);

        // Fairness sweep from a freshly reset pointer
        resetn = 1'b0;
        step(8'h00, 1'b0);
        resetn = 1'b1;
        exp_q.push_back(3'd0);
        step(8'hFF, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(RR ? 3'(k % 8) : 3'd0);
            step(8'hFF, 1'b1);
            check("fair_valid", 32'(bus.out_valid), 32'd1);
        end
        step(8'h00, 1'b1);
        check("fair_idle", 32'(bus.out_valid), 32'd0);

        // Pointer wrap past index 7
        resetn = 1'b0;
        step(8'h00, 1'b0);
        resetn = 1'b1;
        exp_q.push_back(3'd7);
        step(8'h80, 1'b0);
        exp_q.push_back(3'd0);
        step(8'h81, 1'b1);
        exp_q.push_back(RR ? 3'd7 : 3'd0);
        step(8'h81, 1'b1);
        step(8'h00, 1'b1);
        check("wrap_idle", 32'(bus.out_valid), 32'd0);

        // Reset while holding idx 4 drops the grant
        exp_q.push_back(3'd4);
        step(8'h10, 1'b0);
        check("midrst_held_idx", 32'(bus.out_idx), 32'd4);
        resetn = 1'b0;
        step(8'h10, 1'b0);
        exp_q.delete();
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_onehot", 32'(bus.out_onehot), 32'd0);
        resetn = 1'b1;
        exp_q.push_back(3'd0);
        step(8'h11, 1'b0);
        check("midrst_regrant_idx", 32'(bus.out_idx), 32'd0);
        step(8'h00, 1'b1);

        repeat (2) step(8'h00, 1'b0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
